// File: rtl/mmio_pkg.sv
// Shared definitions for the dmem_mmio peripheral window: default base address,
// register byte offsets, CTRL bit positions and timer state encodings.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    // Byte offsets inside the window; only addr[4:2] takes part in the decode
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_COUNT  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_LEDS   = 5'h10;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_W          = 3;

    localparam logic [0:0] TMR_IDLE = 1'b0;
    localparam logic [0:0] TMR_RUN  = 1'b1;

endpackage

// File: rtl/mmio_timer.sv
// Programmable down-counter timer: CTRL/LOAD/COUNT/STATUS registers and expiry logic.
// Optional macro DMEM_MMIO_IRQ_EN stores CTRL.irq_en and drives irq from STATUS & CTRL.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [4:0]        wr_off,
    input  logic [31:0]       wr_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [31:0]       load,
    output logic [31:0]       count,
    output logic              expired,
    output logic              irq
);

`ifdef DMEM_MMIO_IRQ_EN
    localparam logic [CTRL_W-1:0] CTRL_MASK = 3'b111;
`else
    localparam logic [CTRL_W-1:0] CTRL_MASK = 3'b011;
`endif

    logic              wr_ctrl, wr_load, wr_status;
    logic [0:0]        state;
    logic [CTRL_W-1:0] ctrl_d;
    logic [31:0]       load_d, count_d;
    logic              expired_d;

    assign wr_ctrl   = wr_en && (wr_off == OFF_CTRL);
    assign wr_load   = wr_en && (wr_off == OFF_LOAD);
    assign wr_status = wr_en && (wr_off == OFF_STATUS);

    assign state = ctrl[CTRL_ENABLE] ? TMR_RUN : TMR_IDLE;

    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value first,
        // so no branch leaves one unassigned and no latch is inferred.
        ctrl_d    = ctrl;
        load_d    = load;
        count_d   = count;
        expired_d = expired;

        // W1C is applied before expiry so a same-edge expiry wins
        if (wr_status && wr_data[0])
            expired_d = 1'b0;

        case (state)
            TMR_RUN: begin
                if (count == 32'd0) begin
                    expired_d = 1'b1;
                    if (ctrl[CTRL_AUTORELOAD])
                        count_d = load;
                    else
                        ctrl_d[CTRL_ENABLE] = 1'b0;
                end else begin
                    count_d = count - 32'd1;
                end
            end
            default: ;
        endcase

        // Software writes override the timer's own updates
        if (wr_ctrl)
            ctrl_d = wr_data[CTRL_W-1:0] & CTRL_MASK;
        if (wr_load) begin
            load_d  = wr_data;
            count_d = wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            ctrl    <= ctrl_d;
            load    <= load_d;
            count   <= count_d;
            expired <= expired_d;
        end
    end

`ifdef DMEM_MMIO_IRQ_EN
    assign irq = expired & ctrl[CTRL_IRQ_EN];
`else
    assign irq = 1'b0;
`endif

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM plus a memory-mapped window
// holding the mmio_timer and an LED register; combinational reads, clocked writes.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic        timer_expired,
    output logic        irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]       mem [RAM_WORDS];
    logic              ram_hit, mmio_hit;
    logic [AW-1:0]     ram_idx;
    logic [4:0]        reg_off;
    logic [CTRL_W-1:0] tmr_ctrl;
    logic [31:0]       tmr_load, tmr_count;
    logic              unused_addr_lsbs;

    assign ram_hit  = addr < RAM_BYTES;
    assign mmio_hit = !ram_hit && (addr[31:16] == MMIO_BASE[31:16]);
    assign ram_idx  = addr[AW+1:2];
    assign reg_off  = {addr[4:2], 2'b00};

    // Byte lanes are not supported; the low address bits are simply dropped
    assign unused_addr_lsbs = ^addr[1:0];

    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // plain memory; its contents are undefined until written or preloaded.
    always_ff @(posedge clk) begin
        if (memwrite && ram_hit)
            mem[ram_idx] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            leds <= '0;
        else if (memwrite && mmio_hit && reg_off == OFF_LEDS)
            leds <= writedata[7:0];
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (memwrite && mmio_hit),
        .wr_off  (reg_off),
        .wr_data (writedata),
        .ctrl    (tmr_ctrl),
        .load    (tmr_load),
        .count   (tmr_count),
        .expired (timer_expired),
        .irq     (irq)
    );

    always_comb begin
        readdata = 32'h0;
        if (ram_hit) begin
            readdata = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_off)
                OFF_CTRL:   readdata = {{(32-CTRL_W){1'b0}}, tmr_ctrl};
                OFF_LOAD:   readdata = tmr_load;
                OFF_COUNT:  readdata = tmr_count;
                OFF_STATUS: readdata = {31'h0, timer_expired};
                OFF_LEDS:   readdata = {24'h0, leds};
                default:    readdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, decode, timer modes, reset, LEDs and irq.
module tb_dmem_mmio;

    localparam logic [31:0] A_CTRL   = 32'hFFFF_0000;
    localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
    localparam logic [31:0] A_LEDS   = 32'hFFFF_0010;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        timer_expired;
    logic        irq;

    int checks = 0;
    int errors = 0;

    dmem_mmio dut (
        .clk           (clk),
        .reset         (reset),
        .memwrite      (memwrite),
        .addr          (addr),
        .writedata     (writedata),
        .readdata      (readdata),
        .leds          (leds),
        .timer_expired (timer_expired),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        memwrite = 1'b1;
        addr = A_LEDS;
        writedata = 32'hFF;
        step;
        step;
        memwrite = 1'b0;
        reset = 1'b0;
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h want %h", leds, 8'h00); end
        checks++; if (timer_expired !== 1'b0) begin errors++; $display("FAIL reset_expired: got %b want 0", timer_expired); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", v); end
        rd(A_COUNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", v); end
        rd(A_LOAD, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_load: got %h want 0", v); end
    endtask

    task automatic test_ram;
        logic [31:0] v;
        wr(32'h0000_0000, 32'h0BAD_F00D);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_00FC, 32'hCAFE_0001);
        rd(32'h0000_0010, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd10: got %h want DEADBEEF", v); end
        rd(32'h0000_0013, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd13: got %h want DEADBEEF", v); end
        rd(32'h0000_00FC, v);
        checks++; if (v !== 32'hCAFE_0001) begin errors++; $display("FAIL ram_top: got %h want CAFE0001", v); end
    endtask

    task automatic test_unmapped;
        logic [31:0] v;
        wr(32'h8000_0000, 32'h0000_1234);
        wr(32'h0000_0100, 32'h5555_5555);
        rd(32'h8000_0000, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", v); end
        rd(32'h0000_0100, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL past_ram_rd: got %h want 0", v); end
        rd(32'h0000_0000, v);
        checks++; if (v !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_word0_kept: got %h want 0BADF00D", v); end
        wr(32'hFFFF_0014, 32'hFFFF_FFFF);
        rd(32'hFFFF_0014, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mmio_hole_rd: got %h want 0", v); end
        wr(A_COUNT, 32'd55);
        rd(A_COUNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_ro: got %h want 0", v); end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic [31:0] exp_seq [4];
        exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0};
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step;
            rd(A_COUNT, v);
            checks++; if (v !== exp_seq[i]) begin errors++; $display("FAIL oneshot_count[%0d]: got %0d want %0d", i, v, exp_seq[i]); end
        end
        checks++; if (timer_expired !== 1'b0) begin errors++; $display("FAIL oneshot_early_expiry: got %b want 0", timer_expired); end
        step;
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL oneshot_expired: got %b want 1", timer_expired); end
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL oneshot_ctrl_cleared: got %h want 0", v); end
        step;
        rd(A_COUNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL oneshot_count_hold: got %h want 0", v); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h want 1", v); end
        wr(A_STATUS, 32'h1);
        checks++; if (timer_expired !== 1'b0) begin errors++; $display("FAIL oneshot_w1c: got %b want 0", timer_expired); end
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        logic [31:0] exp_cnt [3];
        logic        exp_exp [3];
        exp_cnt = '{32'd1, 32'd0, 32'd2};
        exp_exp = '{1'b0, 1'b0, 1'b1};
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step;
            rd(A_COUNT, v);
            checks++; if (v !== exp_cnt[i]) begin errors++; $display("FAIL auto_count[%0d]: got %0d want %0d", i, v, exp_cnt[i]); end
            checks++; if (timer_expired !== exp_exp[i]) begin errors++; $display("FAIL auto_expired[%0d]: got %b want %b", i, timer_expired, exp_exp[i]); end
        end
        wr(A_STATUS, 32'h1);
        checks++; if (timer_expired !== 1'b0) begin errors++; $display("FAIL auto_w1c: got %b want 0", timer_expired); end
        step;
        wr(A_STATUS, 32'h1);
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL auto_w1c_vs_expiry: got %b want 1", timer_expired); end
        rd(A_COUNT, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL auto_reload: got %0d want 2", v); end
        wr(A_STATUS, 32'h0);
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL auto_w0_no_clear: got %b want 1", timer_expired); end
        wr(A_LOAD, 32'd5);
        rd(A_COUNT, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL load_over_decrement: got %0d want 5", v); end
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'h1);
        // CTRL write landing on the expiry edge keeps the written bits
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'd1);
        step;
        wr(A_CTRL, 32'd3);
        rd(A_CTRL, v);
        checks++; if (v !== 32'd3) begin errors++; $display("FAIL ctrl_wr_on_expiry: got %h want 3", v); end
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL expiry_with_ctrl_wr: got %b want 1", timer_expired); end
        step;
        rd(A_COUNT, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL reload_after_ctrl_wr: got %0d want 1", v); end
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'h1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(A_LEDS, 32'h3C);
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'd1);
        step;
        wr(A_LOAD, 32'd100);
        wr(A_CTRL, 32'd1);
        repeat (10) step;
        rd(A_COUNT, v);
        checks++; if (v !== 32'd90) begin errors++; $display("FAIL mid_count: got %0d want 90", v); end
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL mid_expired_pre: got %b want 1", timer_expired); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        rd(A_COUNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_rst_count: got %h want 0", v); end
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 0", v); end
        checks++; if (timer_expired !== 1'b0) begin errors++; $display("FAIL mid_rst_expired: got %b want 0", timer_expired); end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL mid_rst_leds: got %h want 00", leds); end
    endtask

    task automatic test_leds_irq;
        logic [31:0] v;
        logic [31:0] exp_ctrl_on, exp_ctrl_off;
        logic        exp_irq;
`ifdef DMEM_MMIO_IRQ_EN
        exp_ctrl_on  = 32'd5;
        exp_ctrl_off = 32'd4;
        exp_irq      = 1'b1;
`else
        exp_ctrl_on  = 32'd1;
        exp_ctrl_off = 32'd0;
        exp_irq      = 1'b0;
`endif
        wr(A_LEDS, 32'h1A5);
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL leds_out: got %h want A5", leds); end
        rd(A_LEDS, v);
        checks++; if (v !== 32'hA5) begin errors++; $display("FAIL leds_rd: got %h want A5", v); end
        wr(32'hFFFE_0010, 32'h77);
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL leds_outside_window: got %h want A5", leds); end
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'd5);
        rd(A_CTRL, v);
        checks++; if (v !== exp_ctrl_on) begin errors++; $display("FAIL irq_ctrl_rd: got %h want %h", v, exp_ctrl_on); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_expiry: got %b want 0", irq); end
        step;
        checks++; if (timer_expired !== 1'b1) begin errors++; $display("FAIL zero_count_expiry: got %b want 1", timer_expired); end
        checks++; if (irq !== exp_irq) begin errors++; $display("FAIL irq_after_expiry: got %b want %b", irq, exp_irq); end
        rd(A_CTRL, v);
        checks++; if (v !== exp_ctrl_off) begin errors++; $display("FAIL irq_ctrl_after: got %h want %h", v, exp_ctrl_off); end
        wr(A_STATUS, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        test_reset;
        test_ram;
        test_unmapped;
        test_oneshot;
        test_autoreload;
        test_reset_mid;
        test_leds_irq;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
